uart_tx_param: RTL and testbench
================================

# uart_tx_param

Parametrised UART transmitter for the debug UART interface, successor of the fixed 8N1 transmitter. It serialises DATA_BITS-wide words using a valid/ready handshake, with configurable parity and stop bits. A fractional (phase-accumulator) baud generator keeps the long-run rate exact. Optional escape/pause control frames are included, and the line is shared with a second TX source selected by CHANNEL_I.

## Interface
- CLK_RATE, 100_000_000: clock frequency in Hz.
- BAUD_RATE, 115200: line rate; must satisfy 1 ≤ BAUD_RATE ≤ CLK_RATE/2.
- DATA_BITS, 8: data bits per frame, 5..9.
- PARITY, 0: 0 none, 1 odd, 2 even.
- STOP_BITS, 1: 1 or 2.
- ESC, 'hB1: pause control word, DATA_BITS wide.
- RESUME, 'h00: resume control word, DATA_BITS wide.

- CLK_I  in  1  clock.
- RST_NI  in  1  asynchronous active-low reset.
- DATA_I  in  DATA_BITS  word to send.
- TX_VALID_I  in  1  DATA_I valid.
- TX_READY_O  out  1  transmitter accepts a word this cycle.
- TX_BUSY_O  out  1  frame in progress.
- TX_DONE_O  out  1  one-cycle pulse at the end of every frame, including control frames.
- SEND_PAUSE_I  in  1  request pause signalling (level).
- ESC_DETECTED_I  in  1  the accepted word is an escape; sampled with the handshake.
- CHANNEL_I  in  1  1: line driven by TX2_I.
- TX2_I  in  1  alternate TX source.
- TX_O  out  1  serial line.

## Operation
- TX_O = CHANNEL_I ? TX2_I : tx_q. The mux is combinational; tx_q is a register.
- States:
  - IDLE: tx_q = 1.
  - START: bit value 0.
  - DATA: LSB first, bit counter 0..DATA_BITS-1.
  - PARITY: skipped when PARITY = 0.
  - STOP: STOP_BITS periods at 1.
  - STOP then returns to IDLE.
- Parity bit for odd parity: ~^data. For even parity: ^data.
- Handshake: TX_READY_O = IDLE && !CHANNEL_I && !pause_change. pause_change = SEND_PAUSE_I != pausing_q, and is forced 0 without the macro. Transfer occurs when TX_VALID_I && TX_READY_O.
- On transfer, capture DATA_I into the shift register and last_esc_q ← ESC_DETECTED_I, then go to START.
- Pause handling in IDLE takes priority over data:
  - Rising pause: pausing_q ← 1; if !last_esc_q, send an ESC frame.
  - Falling pause: pausing_q ← 0; if !last_esc_q, send a RESUME frame.
- Baud generator:
  - phase register width $clog2(CLK_RATE+BAUD_RATE)+1; cleared in IDLE.
  - Each non-IDLE cycle: phase += BAUD_RATE.
  - If the sum ≥ CLK_RATE: subtract CLK_RATE and assert tick. The current bit ends and the FSM advances on that tick.
  - Bit periods are floor or ceil of CLK_RATE/BAUD_RATE, with no cumulative drift.
- CHANNEL_I high forces a synchronous abort: state IDLE, pausing_q = 0, last_esc_q = 0, no TX_DONE_O.
- Reset: tx_q = 1, IDLE, phase = 0, pausing_q = 0, last_esc_q = 0. Resulting outputs: TX_BUSY_O = 0, TX_DONE_O = 0, TX_READY_O = !CHANNEL_I && !SEND_PAUSE_I.

## Timing
- tx_q = 0 (start bit) on the cycle after the transfer or pause-frame launch.
- TX_BUSY_O is high from that same cycle through the final stop tick.
- TX_DONE_O pulses in the cycle of the last stop-bit tick. The FSM is IDLE on the next cycle, so TX_READY_O can reassert and the next start bit follows after one idle cycle.
- Frame length is 1 + DATA_BITS + (PARITY≠0) + STOP_BITS ticks.
- Reset assertion mid-frame forces TX_O high (when CHANNEL_I = 0) asynchronously; the frame is lost.
- Pause toggled mid-frame is acted on in the first IDLE cycle after TX_DONE_O. Toggling twice before then produces no control frame.

## Configuration
- UART_TX_ESC_EN defined: pause/ESC/RESUME logic present as described.
- UART_TX_ESC_EN undefined:
  - SEND_PAUSE_I and ESC_DETECTED_I are ignored.
  - pausing_q and last_esc_q are removed.
  - TX_READY_O = IDLE && !CHANNEL_I.

## Test plan
- Settings CLK_RATE=160, BAUD_RATE=10, 8N1; send 'hA5 -> TX_O = 0,1,0,1,0,0,1,0,1,1, each held 16 cycles; TX_DONE_O 160 cycles after the start bit.
- DATA_BITS=7, PARITY=2, STOP_BITS=2; send 'h03 -> 0,1,1,0,0,0,0,0, parity 0, 1,1; 11 bit periods.
- CLK_RATE=100, BAUD_RATE=30 -> bit lengths 4,3,3,4,3,3,4,3,3,4; TX_DONE_O 34 cycles after frame start.
- With UART_TX_ESC_EN, SEND_PAUSE_I rises in IDLE -> 'hB1 frame with TX_READY_O low during it. Falling edge -> 'h00 frame. Repeat after a word sent with ESC_DETECTED_I=1 -> no control frames.
- CHANNEL_I=1 at data bit 3 -> TX_O follows TX2_I the same cycle; no TX_DONE_O. After CHANNEL_I=0 -> TX_O=1 and TX_READY_O=1.
- RST_NI low mid-frame -> TX_O=1 and TX_BUSY_O=0 without a clock edge; after release, 'h5A transmits correctly.

Source files
------------

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: valid/ready input, fractional baud generator, parity and
// stop-bit options, and a combinational mux onto a shared line. Define UART_TX_ESC_EN for pause frames.
module uart_tx_param #(
    parameter int                   CLK_RATE  = 100_000_000,
    parameter int                   BAUD_RATE = 115200,
    parameter int                   DATA_BITS = 8,
    parameter int                   PARITY    = 0,
    parameter int                   STOP_BITS = 1,
    parameter logic [DATA_BITS-1:0] ESC       = DATA_BITS'('hB1),
    parameter logic [DATA_BITS-1:0] RESUME    = DATA_BITS'('h00)
) (
    input  logic                 CLK_I,
    input  logic                 RST_NI,
    input  logic [DATA_BITS-1:0] DATA_I,
    input  logic                 TX_VALID_I,
    output logic                 TX_READY_O,
    output logic                 TX_BUSY_O,
    output logic                 TX_DONE_O,
    input  logic                 SEND_PAUSE_I,
    input  logic                 ESC_DETECTED_I,
    input  logic                 CHANNEL_I,
    input  logic                 TX2_I,
    output logic                 TX_O
);

    localparam int                 PHASE_W   = $clog2(CLK_RATE + BAUD_RATE) + 1;
    localparam int                 CNT_W     = $clog2(DATA_BITS);
    localparam logic [PHASE_W-1:0] BAUD_INC  = PHASE_W'(BAUD_RATE);
    localparam logic [PHASE_W-1:0] CLK_WRAP  = PHASE_W'(CLK_RATE);
    localparam logic [CNT_W-1:0]   LAST_BIT  = CNT_W'(DATA_BITS - 1);
    localparam logic               LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic                 tx_q, tx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 parity_q, parity_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic [PHASE_W-1:0]   phase_sum;
    logic                 tick;
    logic                 ready;
    logic                 done;
    logic                 load;
    logic [DATA_BITS-1:0] load_word;
    logic                 pause_change;

`ifdef UART_TX_ESC_EN
    logic pausing_q, pausing_d;
    logic last_esc_q, last_esc_d;

    assign pause_change = SEND_PAUSE_I != pausing_q;
`else
    logic unused_inputs;

    assign unused_inputs = ^{SEND_PAUSE_I, ESC_DETECTED_I, ESC, RESUME};
    assign pause_change  = 1'b0;
`endif

    assign ready      = (state_q == S_IDLE) && !CHANNEL_I && !pause_change;
    assign TX_READY_O = ready;
    assign TX_BUSY_O  = state_q != S_IDLE;
    assign TX_DONE_O  = done;
    assign TX_O       = CHANNEL_I ? TX2_I : tx_q;

    // The phase keeps its remainder across bits, so bit lengths dither between floor and ceil.
    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        parity_d   = parity_q;
        phase_d    = '0;
        tick       = 1'b0;
        done       = 1'b0;
        load       = 1'b0;
        load_word  = '0;
`ifdef UART_TX_ESC_EN
        pausing_d  = pausing_q;
        last_esc_d = last_esc_q;
`endif
        phase_sum  = phase_q + BAUD_INC;

        if (state_q != S_IDLE) begin
            if (phase_sum >= CLK_WRAP) begin
                tick    = 1'b1;
                phase_d = phase_sum - CLK_WRAP;
            end else begin
                phase_d = phase_sum;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
`ifdef UART_TX_ESC_EN
                if (!CHANNEL_I && pause_change) begin
                    pausing_d = SEND_PAUSE_I;
                    if (!last_esc_q) begin
                        load      = 1'b1;
                        load_word = SEND_PAUSE_I ? ESC : RESUME;
                    end
                end
`endif
                if (TX_VALID_I && ready) begin
                    load      = 1'b1;
                    load_word = DATA_I;
`ifdef UART_TX_ESC_EN
                    last_esc_d = ESC_DETECTED_I;
`endif
                end
            end
            S_START: begin
                if (tick) begin
                    state_d   = S_DATA;
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d    = S_STOP;
                            tx_d       = 1'b1;
                            stop_cnt_d = 1'b0;
                        end
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    state_d    = S_STOP;
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        state_d = S_IDLE;
                        done    = 1'b1;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        if (load) begin
            state_d    = S_START;
            tx_d       = 1'b0;
            shift_d    = load_word;
            parity_d   = (PARITY == 1) ? ~^load_word : ^load_word;
            bit_cnt_d  = '0;
            stop_cnt_d = 1'b0;
        end

        // Handing the line to the second source abandons the frame without a done pulse.
        if (CHANNEL_I) begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            phase_d = '0;
            done    = 1'b0;
`ifdef UART_TX_ESC_EN
            pausing_d  = 1'b0;
            last_esc_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            state_q    <= S_IDLE;
            tx_q       <= 1'b1;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            parity_q   <= 1'b0;
            phase_q    <= '0;
`ifdef UART_TX_ESC_EN
            pausing_q  <= 1'b0;
            last_esc_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            parity_q   <= parity_d;
            phase_q    <= phase_d;
`ifdef UART_TX_ESC_EN
            pausing_q  <= pausing_d;
            last_esc_q <= last_esc_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three configurations checked against a frame and bit-timing model
// computed from ceil(k*CLK_RATE/BAUD_RATE); pause frames are exercised when UART_TX_ESC_EN is defined.
`timescale 1ns/1ps
module tb_uart_tx_param;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] data0, data2;
    logic [6:0] data1;
    logic valid [3];
    logic ready [3];
    logic busy  [3];
    logic done  [3];
    logic pause [3];
    logic escd  [3];
    logic chan  [3];
    logic tx2   [3];
    logic tx    [3];

    int cr_a  [3] = '{160, 160, 100};
    int br_a  [3] = '{10, 10, 30};
    int db_a  [3] = '{8, 7, 8};
    int par_a [3] = '{0, 2, 1};
    int sb_a  [3] = '{1, 2, 1};

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx_param #(.CLK_RATE(160), .BAUD_RATE(10), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
        .CLK_I(clk), .RST_NI(rst_n), .DATA_I(data0), .TX_VALID_I(valid[0]), .TX_READY_O(ready[0]),
        .TX_BUSY_O(busy[0]), .TX_DONE_O(done[0]), .SEND_PAUSE_I(pause[0]), .ESC_DETECTED_I(escd[0]),
        .CHANNEL_I(chan[0]), .TX2_I(tx2[0]), .TX_O(tx[0]));

    uart_tx_param #(.CLK_RATE(160), .BAUD_RATE(10), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut1 (
        .CLK_I(clk), .RST_NI(rst_n), .DATA_I(data1), .TX_VALID_I(valid[1]), .TX_READY_O(ready[1]),
        .TX_BUSY_O(busy[1]), .TX_DONE_O(done[1]), .SEND_PAUSE_I(pause[1]), .ESC_DETECTED_I(escd[1]),
        .CHANNEL_I(chan[1]), .TX2_I(tx2[1]), .TX_O(tx[1]));

    uart_tx_param #(.CLK_RATE(100), .BAUD_RATE(30), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut2 (
        .CLK_I(clk), .RST_NI(rst_n), .DATA_I(data2), .TX_VALID_I(valid[2]), .TX_READY_O(ready[2]),
        .TX_BUSY_O(busy[2]), .TX_DONE_O(done[2]), .SEND_PAUSE_I(pause[2]), .ESC_DETECTED_I(escd[2]),
        .CHANNEL_I(chan[2]), .TX2_I(tx2[2]), .TX_O(tx[2]));

    function automatic int num_bits(input int i);
        return 1 + db_a[i] + ((par_a[i] != 0) ? 1 : 0) + sb_a[i];
    endfunction

    // Offset from the first start-bit cycle of the cycle that ends bit period k (k = 0 gives -1).
    function automatic int tick_at(input int i, input int k);
        return (k * cr_a[i] + br_a[i] - 1) / br_a[i] - 1;
    endfunction

    function automatic logic exp_bit(input int i, input logic [8:0] w, input int j);
        int ones;
        ones = 0;
        for (int b = 0; b < db_a[i]; b++) ones += int'(w[b]);
        if (j == 0) return 1'b0;
        if (j <= db_a[i]) return w[j-1];
        if (par_a[i] != 0 && j == db_a[i] + 1)
            return (par_a[i] == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
        return 1'b1;
    endfunction

    function automatic logic [8:0] rand_word(input int i);
        return 9'($urandom_range(0, (1 << db_a[i]) - 1));
    endfunction

    task automatic set_data(input int i, input logic [8:0] w);
        case (i)
            0:       data0 = w[7:0];
            1:       data1 = w[6:0];
            default: data2 = w[7:0];
        endcase
    endtask

    // Leaves the caller on the negedge holding the first start-bit cycle.
    task automatic send_word(input int i, input logic [8:0] w, input logic e);
        int guard;
        guard = 0;
        #1;
        while (ready[i] !== 1'b1 && guard < 1000) begin
            @(negedge clk);
            #1;
            guard++;
        end
        n_cmp++;
        if (ready[i] !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL send_ready dut%0d: ready=%b required 1", i, ready[i]);
        end
        set_data(i, w);
        escd[i]  = e;
        valid[i] = 1'b1;
        @(negedge clk);
        valid[i] = 1'b0;
        escd[i]  = 1'b0;
    endtask

    task automatic check_frame(input int i, input logic [8:0] w, input string name);
        int   last, j, bad, first_off, first_bit;
        logic exp_tx, exp_done, g_tx, g_busy, g_done, g_ready, e_tx, e_done;
        last = tick_at(i, num_bits(i));
        j = 0; bad = 0; first_off = -1; first_bit = -1;
        g_tx = 0; g_busy = 0; g_done = 0; g_ready = 0; e_tx = 0; e_done = 0;
        for (int o = 0; o <= last; o++) begin
            while (o > tick_at(i, j + 1)) j++;
            exp_tx   = exp_bit(i, w, j);
            exp_done = (o == last);
            if (tx[i] !== exp_tx || busy[i] !== 1'b1 || done[i] !== exp_done || ready[i] !== 1'b0) begin
                if (bad == 0) begin
                    first_off = o; first_bit = j;
                    g_tx = tx[i]; g_busy = busy[i]; g_done = done[i]; g_ready = ready[i];
                    e_tx = exp_tx; e_done = exp_done;
                end
                bad++;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("[TB] FAIL %s dut%0d word=%h: %0d bad cycles, first offset %0d bit %0d: tx=%b busy=%b done=%b ready=%b required tx=%b busy=1 done=%b ready=0",
                     name, i, w, bad, first_off, first_bit, g_tx, g_busy, g_done, g_ready, e_tx, e_done);
        end
        n_cmp++;
        if (tx[i] !== 1'b1 || busy[i] !== 1'b0 || done[i] !== 1'b0 || ready[i] !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL %s_idle dut%0d: tx=%b busy=%b done=%b ready=%b required 1 0 0 1",
                     name, i, tx[i], busy[i], done[i], ready[i]);
        end
    endtask

    // Watches the line for n cycles expecting no frame at all.
    task automatic check_quiet(input int i, input int n, input string name);
        int bad;
        bad = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (tx[i] !== 1'b1 || busy[i] !== 1'b0 || done[i] !== 1'b0 || ready[i] !== 1'b1) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("[TB] FAIL %s dut%0d: %0d active cycles, last tx=%b busy=%b ready=%b required 0 active",
                     name, i, bad, tx[i], busy[i], ready[i]);
        end
    endtask

    task automatic test_reset;
        logic exp_ready;
        rst_n = 1'b0;
        pause[0] = 1'b1;
        chan[2]  = 1'b1;
        tx2[2]   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (busy[i] !== 1'b0 || done[i] !== 1'b0) begin
                n_bad++;
                $display("[TB] FAIL reset_state dut%0d: busy=%b done=%b required 0 0", i, busy[i], done[i]);
            end
        end
`ifdef UART_TX_ESC_EN
        exp_ready = 1'b0;
`else
        exp_ready = 1'b1;
`endif
        n_cmp++;
        if (tx[0] !== 1'b1 || ready[0] !== exp_ready) begin
            n_bad++;
            $display("[TB] FAIL reset_pause dut0: tx=%b ready=%b required 1 %b", tx[0], ready[0], exp_ready);
        end
        n_cmp++;
        if (tx[1] !== 1'b1 || ready[1] !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL reset_ready dut1: tx=%b ready=%b required 1 1", tx[1], ready[1]);
        end
        n_cmp++;
        if (tx[2] !== 1'b0 || ready[2] !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL reset_chan dut2: tx=%b ready=%b required 0 0", tx[2], ready[2]);
        end
        pause[0] = 1'b0;
        chan[2]  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_vectors;
        send_word(0, 9'h0A5, 1'b0);
        check_frame(0, 9'h0A5, "vec_a5_8n1");
        send_word(1, 9'h003, 1'b0);
        check_frame(1, 9'h003, "vec_03_7e2");
        send_word(2, 9'h096, 1'b0);
        check_frame(2, 9'h096, "vec_frac_baud");
    endtask

    task automatic test_random;
        logic [8:0] w;
        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 4; n++) begin
                w = rand_word(i);
                send_word(i, w, 1'b0);
                check_frame(i, w, "random");
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [8:0] a, b;
        a = rand_word(1);
        b = rand_word(1);
        send_word(1, a, 1'b0);
        check_frame(1, a, "b2b_first");
        send_word(1, b, 1'b0);
        check_frame(1, b, "b2b_second");
    endtask

    task automatic test_channel;
        logic [8:0] w;
        int bad;
        w = rand_word(0);
        send_word(0, w, 1'b0);
        repeat (tick_at(0, 4) + 1) @(negedge clk);
        n_cmp++;
        if (tx[0] !== exp_bit(0, w, 4)) begin
            n_bad++;
            $display("[TB] FAIL chan_pre dut0: tx=%b required %b", tx[0], exp_bit(0, w, 4));
        end
        chan[0] = 1'b1;
        tx2[0]  = ~exp_bit(0, w, 4);
        #1;
        n_cmp++;
        if (tx[0] !== tx2[0]) begin
            n_bad++;
            $display("[TB] FAIL chan_mux dut0: tx=%b required %b", tx[0], tx2[0]);
        end
        bad = 0;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            tx2[0] = 1'($urandom_range(0, 1));
            #1;
            if (tx[0] !== tx2[0] || done[0] !== 1'b0 || busy[0] !== 1'b0 || ready[0] !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("[TB] FAIL chan_follow dut0: %0d bad cycles, last tx=%b done=%b busy=%b required tx=tx2 done=0 busy=0",
                     bad, tx[0], done[0], busy[0]);
        end
        @(negedge clk);
        chan[0] = 1'b0;
        #1;
        n_cmp++;
        if (tx[0] !== 1'b1 || ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL chan_release dut0: tx=%b ready=%b busy=%b required 1 1 0", tx[0], ready[0], busy[0]);
        end
        w = rand_word(0);
        send_word(0, w, 1'b0);
        check_frame(0, w, "chan_recover");
    endtask

    task automatic test_reset_midframe;
        send_word(0, 9'h05A, 1'b0);
        repeat (50) @(negedge clk);
        n_cmp++;
        if (tx[0] !== exp_bit(0, 9'h05A, 3)) begin
            n_bad++;
            $display("[TB] FAIL rst_pre dut0: tx=%b required %b", tx[0], exp_bit(0, 9'h05A, 3));
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (tx[0] !== 1'b1 || busy[0] !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL rst_async dut0: tx=%b busy=%b required 1 0", tx[0], busy[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_word(0, 9'h05A, 1'b0);
        check_frame(0, 9'h05A, "rst_resend_5a");
    endtask

`ifdef UART_TX_ESC_EN
    task automatic test_pause;
        logic [8:0] w;
        int guard;
        w = rand_word(2);
        send_word(2, w, 1'b0);
        check_frame(2, w, "pause_prep");
        pause[2] = 1'b1;
        #1;
        n_cmp++;
        if (ready[2] !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL pause_ready dut2: ready=%b required 0", ready[2]);
        end
        @(negedge clk);
        check_frame(2, 9'h0B1, "pause_esc");
        pause[2] = 1'b0;
        @(negedge clk);
        check_frame(2, 9'h000, "pause_resume");
        w = rand_word(2);
        send_word(2, w, 1'b1);
        check_frame(2, w, "esc_word");
        pause[2] = 1'b1;
        check_quiet(2, 40, "pause_after_esc");
        pause[2] = 1'b0;
        check_quiet(2, 40, "resume_after_esc");
        w = rand_word(2);
        send_word(2, w, 1'b0);
        repeat (8) @(negedge clk);
        pause[2] = 1'b1;
        repeat (8) @(negedge clk);
        pause[2] = 1'b0;
        guard = 0;
        while (done[2] !== 1'b1 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (done[2] !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL toggle_done dut2: done=%b required 1 within 400 cycles", done[2]);
        end
        check_quiet(2, 60, "toggle_twice");
    endtask
`else
    task automatic test_pause_ignored;
        pause[0] = 1'b1;
        escd[0]  = 1'b1;
        check_quiet(0, 40, "pause_ignored");
        pause[0] = 1'b0;
        escd[0]  = 1'b0;
        check_quiet(0, 20, "pause_released");
    endtask
`endif

    initial begin
        for (int i = 0; i < 3; i++) begin
            valid[i] = 1'b0;
            pause[i] = 1'b0;
            escd[i]  = 1'b0;
            chan[i]  = 1'b0;
            tx2[i]   = 1'b1;
        end
        data0 = '0;
        data1 = '0;
        data2 = '0;
        test_reset;
        test_vectors;
        test_random;
        test_back_to_back;
        test_channel;
        test_reset_midframe;
`ifdef UART_TX_ESC_EN
        test_pause;
`else
        test_pause_ignored;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] time limit");
    end

endmodule
